udma_i2c_cmd_arbiter: RTL and testbench
=======================================

// Module: udma_i2c_cmd_arbiter
// PURPOSE
//  Shares one I2C control engine (cmd/tx/rx stream ports) between NUM_REQ uDMA requester channels.
//  Round-robin arbitration at transaction granularity: an owner keeps the engine from its first
//  bus command until its STOP is accepted, so transactions never interleave on the wire.
//  Sits between the per-channel uDMA streams and the I2C control engine's command/data ports.
// PARAMETERS
//  NUM_REQ    2   number of requester channels (2..8)
//  TIMEOUT_W  16  width of lock-watchdog counter/threshold
// PORTS
//  clk_i            in   1          clock; sole clock domain
//  rst_i            in   1          asynchronous, active-high reset
//  sw_rst_i         in   1          synchronous soft reset, same effect as rst_i
//  req_cmd_i        in   NUM_REQx32 per-requester command word ([31:28] opcode, I2C_CMD_* defines)
//  req_cmd_valid_i  in   NUM_REQ    command valid
//  req_cmd_ready_o  out  NUM_REQ    command ready
//  req_tx_i         in   NUM_REQx8  per-requester write data
//  req_tx_valid_i   in   NUM_REQ    / req_tx_ready_o out NUM_REQ: write-data handshake
//  req_rx_o         out  NUM_REQx8  read data (all lanes carry eng_rx_i)
//  req_rx_valid_o   out  NUM_REQ    / req_rx_ready_i in NUM_REQ: read-data handshake
//  eng_cmd_o        out  32         / eng_cmd_valid_o out 1 / eng_cmd_ready_i in 1: to engine
//  eng_tx_o         out  8          / eng_tx_valid_o out 1 / eng_tx_ready_i in 1: to engine
//  eng_rx_i         in   8          / eng_rx_valid_i in 1 / eng_rx_ready_o out 1: from engine
//  owner_o          out  $clog2(NUM_REQ)  current/last owner index
//  locked_o         out  1          transaction lock held
//  timeout_cfg_i    in   TIMEOUT_W  watchdog threshold in cycles; 0 = watchdog off
//  timeout_o        out  1          1-cycle pulse when the watchdog fires
// BEHAVIOUR
//  Reset (rst_i or sw_rst_i): state IDLE, rr pointer 0, owner 0, counter 0; all valid/ready outputs 0, locked_o 0, timeout_o 0.
//  States: IDLE, LOCKED, FLUSH (FLUSH exists only with macro).
//  IDLE: rr picker chooses first valid requester at/after pointer; eng_cmd_o/valid driven combinationally
//   from the pick (0 cmd latency); req_cmd_ready_o only at pick = eng_cmd_ready_i; others 0.
//   On handshake: owner<=pick. Opcode CFG, WAIT or WAIT_EV -> stay IDLE, pointer<=pick+1 (mod NUM_REQ).
//   Opcode STOP -> stay IDLE, pointer<=pick+1. Any other opcode -> LOCKED.
//  LOCKED: only owner's cmd/tx/rx are connected; non-owner readies/valids 0 even if eng ready.
//   tx/rx are routed to owner in every state (tx needed after WR, rx after RD); no buffering.
//   Handshake of a STOP word from owner -> IDLE, pointer<=owner+1. Other opcodes stay LOCKED.
//  Simultaneous valids: pure rr from pointer; no requester waits more than NUM_REQ-1 transactions.
//  Requester dropping valid before handshake is a protocol error; cmd mux re-picks combinationally.
//  Pointer wraps NUM_REQ-1 -> 0. locked_o = (state != IDLE).
// CONFIGURATION
//  Macro UDMA_I2C_ARB_TIMEOUT_EN:
//   defined: counter clears on any owner cmd/tx/rx handshake or state change, +1 each LOCKED cycle;
//    when timeout_cfg_i!=0 and counter==timeout_cfg_i -> FLUSH. FLUSH: eng_cmd_o = {I2C_CMD_STOP,28'h0},
//    eng_cmd_valid_o=1, all requester readies/valids 0; on eng_cmd_ready_i -> IDLE, pointer<=owner+1,
//    timeout_o pulses that cycle. Counter saturates; never wraps.
//   undefined: no counter, no FLUSH; timeout_cfg_i ignored; timeout_o tied 0; lock held indefinitely.
// STRUCTURE
//  Package udma_i2c_arb_pkg: state enum, opcode-class function (is_single_cmd), STOP-word constant;
//   opcode values taken from udma_i2c_defines.sv.
//  Sub-module udma_i2c_rr_picker: NUM_REQ valid vector + pointer -> one-hot/idx pick, pure combinational.
// TESTING
//  NUM_REQ=2; both send START,WR(2B),STOP same cycle, ptr=0 -> req0 full txn first, then req1; no interleave.
//  req1 sends CFG while req0 LOCKED -> CFG held (ready 0) until req0 STOP accepted, then forwarded.
//  IDLE, req0 CFG and req1 CFG together -> req0 then req1 in consecutive cycles, IDLE throughout.
//  req0 RD_ACK x1 inside lock, eng_rx_valid_i with 8'hA5 -> only req_rx_valid_o[0]=1, data 8'hA5.
//  Macro on, timeout_cfg_i=10, req0 idles after START -> STOP injected on cycle 10, timeout_o 1 pulse, IDLE.
//  rst_i asserted mid-LOCKED with eng_cmd_valid_o=1 -> all outputs 0 asynchronously, IDLE, ptr 0 after release.

Source files
------------

// File: rtl/udma_i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// udma_i2c_arb_pkg
// Shared definitions for the uDMA I2C command arbiter:
//   - I2C command opcodes (bits [31:28] of a command word), matching the
//     I2C_CMD_* values of udma_i2c_defines.sv
//   - the STOP command word injected by the lock watchdog
//   - arbiter state encoding
//   - opcode classification helpers
// Optional feature macro: UDMA_I2C_ARB_TIMEOUT_EN (adds the FLUSH state).
// ---------------------------------------------------------------------------
package udma_i2c_arb_pkg;

  localparam logic [3:0] I2C_CMD_START   = 4'h0;
  localparam logic [3:0] I2C_CMD_WAIT_EV = 4'h1;
  localparam logic [3:0] I2C_CMD_STOP    = 4'h2;
  localparam logic [3:0] I2C_CMD_RD_ACK  = 4'h4;
  localparam logic [3:0] I2C_CMD_RD_NACK = 4'h6;
  localparam logic [3:0] I2C_CMD_WR      = 4'h8;
  localparam logic [3:0] I2C_CMD_WAIT    = 4'hA;
  localparam logic [3:0] I2C_CMD_RPT     = 4'hC;
  localparam logic [3:0] I2C_CMD_CFG     = 4'hE;

  // Command word the watchdog pushes to close an abandoned transaction.
  localparam logic [31:0] I2C_STOP_WORD = {I2C_CMD_STOP, 28'h0};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    ST_FLUSH  = 2'd2,
`endif
    ST_LOCKED = 2'd1
  } arb_state_t;

  // Commands that never touch the bus lock: they are forwarded and the
  // engine is immediately offered to the next requester.
  function automatic logic is_single_cmd(input logic [3:0] op);
    return (op == I2C_CMD_CFG) || (op == I2C_CMD_WAIT) || (op == I2C_CMD_WAIT_EV);
  endfunction

  function automatic logic is_stop_cmd(input logic [3:0] op);
    return op == I2C_CMD_STOP;
  endfunction

endpackage

// File: rtl/udma_i2c_rr_picker.sv
// ---------------------------------------------------------------------------
// udma_i2c_rr_picker
// Purely combinational round-robin selector: returns the first asserted
// request at or after the pointer position, wrapping NUM_REQ-1 -> 0.
// Ports:
//   valid   in  NUM_REQ  request vector
//   ptr     in  IDX_W    highest-priority index this cycle
//   onehot  out NUM_REQ  one-hot grant (all zero when no request)
//   idx     out IDX_W    granted index (0 when no request)
//   any     out 1        at least one request asserted
// ---------------------------------------------------------------------------
module udma_i2c_rr_picker #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  // Scan offsets from the far end back to the pointer so the nearest
  // requester at/after the pointer is the last (winning) assignment.
  always_comb begin
    idx    = '0;
    onehot = '0;
    any    = |valid;
    j      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (valid[j]) idx = IDX_W'(j);
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/udma_i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// udma_i2c_cmd_arbiter
// Shares one I2C control engine between NUM_REQ uDMA requester channels with
// round-robin arbitration at transaction granularity: a requester that issues
// a bus command (anything except CFG/WAIT/WAIT_EV/STOP) owns the engine until
// its STOP is accepted. tx/rx data are always routed to the current owner.
// Ports:
//   clk_i, rst_i (async, active high), sw_rst_i (sync soft reset)
//   req_cmd_*  per-requester command stream (32-bit, opcode in [31:28])
//   req_tx_*   per-requester write data stream
//   req_rx_*   per-requester read data stream (all lanes carry eng_rx_i)
//   eng_cmd_*, eng_tx_*, eng_rx_*  engine side streams
//   owner_o    current/last owner, locked_o  transaction lock held
//   timeout_cfg_i / timeout_o      lock watchdog threshold and fire pulse
// Optional feature macro: UDMA_I2C_ARB_TIMEOUT_EN enables the lock watchdog
// and FLUSH state; without it timeout_cfg_i is ignored and timeout_o is 0.
// ---------------------------------------------------------------------------
module udma_i2c_cmd_arbiter
  import udma_i2c_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TIMEOUT_W = 16,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      sw_rst_i,
  input  logic [NUM_REQ-1:0][31:0]  req_cmd_i,
  input  logic [NUM_REQ-1:0]        req_cmd_valid_i,
  output logic [NUM_REQ-1:0]        req_cmd_ready_o,
  input  logic [NUM_REQ-1:0][7:0]   req_tx_i,
  input  logic [NUM_REQ-1:0]        req_tx_valid_i,
  output logic [NUM_REQ-1:0]        req_tx_ready_o,
  output logic [NUM_REQ-1:0][7:0]   req_rx_o,
  output logic [NUM_REQ-1:0]        req_rx_valid_o,
  input  logic [NUM_REQ-1:0]        req_rx_ready_i,
  output logic [31:0]               eng_cmd_o,
  output logic                      eng_cmd_valid_o,
  input  logic                      eng_cmd_ready_i,
  output logic [7:0]                eng_tx_o,
  output logic                      eng_tx_valid_o,
  input  logic                      eng_tx_ready_i,
  input  logic [7:0]                eng_rx_i,
  input  logic                      eng_rx_valid_i,
  output logic                      eng_rx_ready_o,
  output logic [IDX_W-1:0]          owner_o,
  output logic                      locked_o,
  input  logic [TIMEOUT_W-1:0]      timeout_cfg_i,
  output logic                      timeout_o
);

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               active;
  logic               route_data;
  logic               cmd_hs;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  udma_i2c_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid  (req_cmd_valid_i),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Handshake-carrying outputs are forced low while either reset is active,
  // so the engine never sees a command during (or straight out of) reset.
  assign active     = ~(rst_i | sw_rst_i);
  assign route_data = (state_reg == ST_IDLE) || (state_reg == ST_LOCKED);
  assign owner_o    = owner_reg;
  assign locked_o   = (state_reg != ST_IDLE);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rx_data
    assign req_rx_o[gi] = eng_rx_i;
  end

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;
  logic                 data_hs;

  // Any owner data beat proves the transaction is still alive.
  assign data_hs = route_data &
                   ((req_tx_valid_i[owner_reg] & eng_tx_ready_i) |
                    (eng_rx_valid_i & req_rx_ready_i[owner_reg]));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^timeout_cfg_i;
`endif

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    owner_next      = owner_reg;
    eng_cmd_o       = '0;
    eng_cmd_valid_o = 1'b0;
    req_cmd_ready_o = '0;
    eng_tx_o        = '0;
    eng_tx_valid_o  = 1'b0;
    req_tx_ready_o  = '0;
    req_rx_valid_o  = '0;
    eng_rx_ready_o  = 1'b0;
    timeout_o       = 1'b0;
    cmd_hs          = 1'b0;

    // Data streams follow the owner register; they are not buffered.
    if (route_data) begin
      eng_tx_o                  = req_tx_i[owner_reg];
      eng_tx_valid_o            = req_tx_valid_i[owner_reg];
      req_tx_ready_o[owner_reg] = eng_tx_ready_i;
      req_rx_valid_o[owner_reg] = eng_rx_valid_i;
      eng_rx_ready_o            = req_rx_ready_i[owner_reg];
    end

    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          eng_cmd_o       = req_cmd_i[pick_idx];
          eng_cmd_valid_o = 1'b1;
          req_cmd_ready_o = pick_onehot & {NUM_REQ{eng_cmd_ready_i}};
          if (eng_cmd_ready_i) begin
            owner_next = pick_idx;
            if (is_single_cmd(req_cmd_i[pick_idx][31:28]) ||
                is_stop_cmd(req_cmd_i[pick_idx][31:28])) begin
              ptr_next = next_idx(pick_idx);
            end else begin
              state_next = ST_LOCKED;
            end
          end
        end
      end

      ST_LOCKED: begin
        eng_cmd_o                  = req_cmd_i[owner_reg];
        eng_cmd_valid_o            = req_cmd_valid_i[owner_reg];
        req_cmd_ready_o[owner_reg] = eng_cmd_ready_i;
        cmd_hs = req_cmd_valid_i[owner_reg] & eng_cmd_ready_i;
        if (cmd_hs && is_stop_cmd(req_cmd_i[owner_reg][31:28])) begin
          state_next = ST_IDLE;
          ptr_next   = next_idx(owner_reg);
        end
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
        else if (!cmd_hs && !data_hs && (timeout_cfg_i != '0) &&
                 (cnt_reg == timeout_cfg_i)) begin
          state_next = ST_FLUSH;
        end
`endif
      end

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
      ST_FLUSH: begin
        // Close the abandoned transaction on the wire; requesters see nothing.
        eng_cmd_o       = I2C_STOP_WORD;
        eng_cmd_valid_o = 1'b1;
        if (eng_cmd_ready_i) begin
          state_next = ST_IDLE;
          ptr_next   = next_idx(owner_reg);
          timeout_o  = 1'b1;
        end
      end
`endif

      default: state_next = ST_IDLE;
    endcase

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    cnt_next = cnt_reg;
    if ((state_next != state_reg) || cmd_hs || data_hs) begin
      cnt_next = '0;
    end else if ((state_reg == ST_LOCKED) && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + 1'b1;
    end
`endif

    if (!active) begin
      eng_cmd_valid_o = 1'b0;
      req_cmd_ready_o = '0;
      eng_tx_valid_o  = 1'b0;
      req_tx_ready_o  = '0;
      req_rx_valid_o  = '0;
      eng_rx_ready_o  = 1'b0;
      timeout_o       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else if (sw_rst_i) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (sw_rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_udma_i2c_cmd_arbiter.sv
module tb_udma_i2c_cmd_arbiter;

  localparam int NR = 2;

  localparam logic [3:0] OP_START   = 4'h0;
  localparam logic [3:0] OP_WAIT_EV = 4'h1;
  localparam logic [3:0] OP_STOP    = 4'h2;
  localparam logic [3:0] OP_RD_ACK  = 4'h4;
  localparam logic [3:0] OP_RD_NACK = 4'h6;
  localparam logic [3:0] OP_WR      = 4'h8;
  localparam logic [3:0] OP_WAIT    = 4'hA;
  localparam logic [3:0] OP_RPT     = 4'hC;
  localparam logic [3:0] OP_CFG     = 4'hE;

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, sw_rst;
  logic [NR-1:0][31:0]  req_cmd;
  logic [NR-1:0]        req_cmd_valid, req_cmd_ready;
  logic [NR-1:0][7:0]   req_tx;
  logic [NR-1:0]        req_tx_valid, req_tx_ready;
  logic [NR-1:0][7:0]   req_rx;
  logic [NR-1:0]        req_rx_valid, req_rx_ready;
  logic [31:0]          eng_cmd;
  logic                 eng_cmd_valid, eng_cmd_ready;
  logic [7:0]           eng_tx;
  logic                 eng_tx_valid, eng_tx_ready;
  logic [7:0]           eng_rx;
  logic                 eng_rx_valid, eng_rx_ready;
  logic [0:0]           owner;
  logic                 locked;
  logic [15:0]          timeout_cfg;
  logic                 timeout;

  udma_i2c_cmd_arbiter #(.NUM_REQ(NR), .TIMEOUT_W(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sw_rst_i        (sw_rst),
    .req_cmd_i       (req_cmd),
    .req_cmd_valid_i (req_cmd_valid),
    .req_cmd_ready_o (req_cmd_ready),
    .req_tx_i        (req_tx),
    .req_tx_valid_i  (req_tx_valid),
    .req_tx_ready_o  (req_tx_ready),
    .req_rx_o        (req_rx),
    .req_rx_valid_o  (req_rx_valid),
    .req_rx_ready_i  (req_rx_ready),
    .eng_cmd_o       (eng_cmd),
    .eng_cmd_valid_o (eng_cmd_valid),
    .eng_cmd_ready_i (eng_cmd_ready),
    .eng_tx_o        (eng_tx),
    .eng_tx_valid_o  (eng_tx_valid),
    .eng_tx_ready_i  (eng_tx_ready),
    .eng_rx_i        (eng_rx),
    .eng_rx_valid_i  (eng_rx_valid),
    .eng_rx_ready_o  (eng_rx_ready),
    .owner_o         (owner),
    .locked_o        (locked),
    .timeout_cfg_i   (timeout_cfg),
    .timeout_o       (timeout)
  );

  int tests = 0;
  int fails = 0;

  // Pending command words per requester and accepted words on the engine.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] log_q[$];
  logic [31:0] exp_log[$];

  // Reference model: 0 = free, 1 = held by m_owner, 2 = watchdog closing it.
  int m_state, m_ptr, m_owner, m_idle;
  bit rnd_aux;
  logic eng_rdy_val;
  int to_pulses;
  int seq = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [3:0] op, input int r);
    seq++;
    return {op, 4'(r), 24'(seq)};
  endfunction

  task automatic push(input int r, input logic [31:0] w);
    if (r == 0) q0.push_back(w); else q1.push_back(w);
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_owner = 0; m_idle = 0;
  endtask

  task automatic tick();
    int grant;
    logic hs, act, e_cv, e_txv, e_rxr, e_to;
    logic [31:0] e_cmd;
    logic [7:0] e_tx;
    logic [NR-1:0] e_cr, e_txr, e_rxv;
    logic [3:0] op;
    req_cmd_valid[0] = (q0.size() != 0);
    req_cmd[0]       = (q0.size() != 0) ? q0[0] : 32'h0;
    req_cmd_valid[1] = (q1.size() != 0);
    req_cmd[1]       = (q1.size() != 0) ? q1[0] : 32'h0;
    if (rnd_aux) begin
      eng_cmd_ready = ($urandom_range(0, 3) != 0);
      req_tx_valid  = NR'($urandom);
      req_tx[0]     = 8'($urandom);
      req_tx[1]     = 8'($urandom);
      eng_tx_ready  = 1'($urandom);
      eng_rx_valid  = 1'($urandom);
      eng_rx        = 8'($urandom);
      req_rx_ready  = NR'($urandom);
    end else begin
      eng_cmd_ready = eng_rdy_val;
    end
    #3;
    grant = -1; e_cv = 0; e_cmd = 0; e_cr = 0; e_txv = 0; e_tx = 0; e_txr = 0;
    e_rxv = 0; e_rxr = 0; e_to = 0;
    if (!sw_rst) begin
      if (m_state == 0) begin
        for (int k = 0; k < NR; k++) begin
          int r;
          r = (m_ptr + k) % NR;
          if (grant < 0 && req_cmd_valid[r]) grant = r;
        end
        if (grant >= 0) begin
          e_cv = 1; e_cmd = req_cmd[grant]; e_cr[grant] = eng_cmd_ready;
        end
      end else if (m_state == 1) begin
        e_cv = req_cmd_valid[m_owner]; e_cmd = req_cmd[m_owner];
        e_cr[m_owner] = eng_cmd_ready;
        if (e_cv) grant = m_owner;
      end else begin
        e_cv = 1; e_cmd = {OP_STOP, 28'h0}; e_to = eng_cmd_ready;
      end
      if (m_state != 2) begin
        e_txv = req_tx_valid[m_owner]; e_tx = req_tx[m_owner];
        e_txr[m_owner] = eng_tx_ready; e_rxv[m_owner] = eng_rx_valid;
        e_rxr = req_rx_ready[m_owner];
      end
    end
    check("eng_cmd_valid", 32'(eng_cmd_valid), 32'(e_cv));
    if (e_cv) check("eng_cmd", eng_cmd, e_cmd);
    check("req_cmd_ready", 32'(req_cmd_ready), 32'(e_cr));
    check("eng_tx_valid", 32'(eng_tx_valid), 32'(e_txv));
    if (e_txv) check("eng_tx", 32'(eng_tx), 32'(e_tx));
    check("req_tx_ready", 32'(req_tx_ready), 32'(e_txr));
    check("req_rx_valid", 32'(req_rx_valid), 32'(e_rxv));
    check("eng_rx_ready", 32'(eng_rx_ready), 32'(e_rxr));
    check("req_rx_data", 32'({req_rx[1], req_rx[0]}), 32'({eng_rx, eng_rx}));
    check("locked", 32'(locked), 32'(m_state != 0));
    check("owner", 32'(owner), 32'(m_owner));
    check("timeout", 32'(timeout), 32'(e_to));
    if (timeout === 1'b1) to_pulses++;
    @(posedge clk);
    #1;
    if (sw_rst) begin
      model_reset();
    end else begin
      hs  = (grant >= 0) && eng_cmd_ready;
      act = hs || (e_txv && eng_tx_ready) || (eng_rx_valid && e_rxr);
      op  = e_cmd[31:28];
      if (hs) begin
        log_q.push_back(e_cmd);
        $display("[TB] t=%0t req%0d cmd %h accepted", $time, grant, e_cmd);
        if (grant == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (m_state == 0) begin
        if (hs) begin
          m_owner = grant;
          if (op inside {OP_CFG, OP_WAIT, OP_WAIT_EV, OP_STOP}) m_ptr = (grant + 1) % NR;
          else begin m_state = 1; m_idle = 0; end
        end
      end else if (m_state == 1) begin
        if (hs && op == OP_STOP) begin
          m_state = 0; m_ptr = (m_owner + 1) % NR;
        end else if (act) m_idle = 0;
        else if (TO_EN && timeout_cfg != 0 && m_idle == int'(timeout_cfg)) m_state = 2;
        else m_idle++;
      end else if (eng_cmd_ready) begin
        m_state = 0; m_ptr = (m_owner + 1) % NR;
        $display("[TB] t=%0t watchdog STOP accepted", $time);
      end
    end
  endtask

  task automatic run_idle(input int budget, output int n);
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_state != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(q0.size() == 0 && q1.size() == 0 && m_state == 0), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
      check(tag, log_q[i], exp_log[i]);
  endtask

  task automatic push_rand_txn(input int r);
    int kind, nb;
    logic [3:0] op;
    kind = $urandom_range(0, 3);
    if (kind == 0) begin
      case ($urandom_range(0, 2))
        0: op = OP_CFG;
        1: op = OP_WAIT;
        default: op = OP_WAIT_EV;
      endcase
      push(r, word(op, r));
    end else if (kind == 1) begin
      push(r, word(OP_STOP, r));
    end else begin
      push(r, word(OP_START, r));
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) begin
        case ($urandom_range(0, 3))
          0: op = OP_WR;
          1: op = OP_RD_ACK;
          2: op = OP_RD_NACK;
          default: op = OP_RPT;
        endcase
        push(r, word(op, r));
      end
      push(r, word(OP_STOP, r));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n, gen, cyc;
    logic [31:0] w;
    rst = 1; sw_rst = 0; req_cmd = '0; req_cmd_valid = '0; req_tx = '0; req_tx_valid = '0;
    req_rx_ready = '0; eng_cmd_ready = 0; eng_tx_ready = 0; eng_rx = '0; eng_rx_valid = 0;
    timeout_cfg = '0; rnd_aux = 0; eng_rdy_val = 1; to_pulses = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    eng_cmd_ready = 1; req_cmd_valid = 2'b11; req_cmd[0] = {OP_START, 28'h1};
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_eng_valid", 32'(eng_cmd_valid), 32'd0);
    check("rst_cmd_ready", 32'(req_cmd_ready), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    req_cmd_valid = '0;
    @(posedge clk);
    #1;
    rst = 0;

    // Both requesters: START, WR, WR, STOP together -> req0 whole, then req1.
    log_q.delete(); exp_log.delete();
    for (int r = 0; r < NR; r++) begin
      w = word(OP_START, r); push(r, w); exp_log.push_back(w);
      w = word(OP_WR, r);    push(r, w); exp_log.push_back(w);
      w = word(OP_WR, r);    push(r, w); exp_log.push_back(w);
      w = word(OP_STOP, r);  push(r, w); exp_log.push_back(w);
    end
    run_idle(50, n);
    check_log("txn_order");
    check("txn_cycles", 32'(n), 32'd8);

    // Two CFG words in IDLE: consecutive cycles, lock never taken.
    log_q.delete(); exp_log.delete();
    w = word(OP_CFG, 0); push(0, w); exp_log.push_back(w);
    w = word(OP_CFG, 1); push(1, w); exp_log.push_back(w);
    run_idle(20, n);
    check_log("cfg_order");
    check("cfg_cycles", 32'(n), 32'd2);

    // req1 CFG held while req0 holds the lock.
    log_q.delete(); exp_log.delete();
    w = word(OP_START, 0); push(0, w); exp_log.push_back(w);
    w = word(OP_CFG, 1);   push(1, w);
    repeat (6) tick();
    check("cfg_held", 32'(q1.size()), 32'd1);
    exp_log.push_back(word(OP_STOP, 0)); push(0, exp_log[1]);
    exp_log.push_back(w);
    run_idle(20, n);
    check_log("held_order");

    // Read data inside a lock reaches only the owner.
    push(0, word(OP_START, 0)); push(0, word(OP_RD_ACK, 0));
    repeat (2) tick();
    eng_rx = 8'hA5; eng_rx_valid = 1; req_rx_ready = 2'b11;
    #3;
    check("rx_valid_owner", 32'(req_rx_valid), 32'b01);
    check("rx_data", 32'(req_rx[0]), 32'hA5);
    tick();
    eng_rx_valid = 0; req_rx_ready = '0;
    push(0, word(OP_STOP, 0));
    run_idle(20, n);

    // Abandoned lock with a 10-cycle watchdog threshold.
    timeout_cfg = 16'd10; to_pulses = 0;
    push(0, word(OP_START, 0));
    tick();
    cyc = 0;
    while (locked === 1'b1 && cyc < 40) begin tick(); cyc++; end
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    // counter reads 0..10 over 11 idle LOCKED cycles, then one FLUSH cycle
    check("wdog_cycles", 32'(cyc), 32'(int'(timeout_cfg) + 2));
    check("wdog_pulses", 32'(to_pulses), 32'd1);
    check("wdog_idle", 32'(locked), 32'd0);
`else
    check("lock_held", 32'(locked), 32'd1);
    check("no_pulse", 32'(to_pulses), 32'd0);
    timeout_cfg = '0;
    push(0, word(OP_STOP, 0));
    run_idle(20, n);
`endif
    timeout_cfg = '0;

    // Async reset mid-lock while a command is being offered.
    push(0, word(OP_CFG, 0));
    run_idle(10, n);
    push(1, word(OP_START, 1));
    tick();
    push(1, word(OP_WR, 1));
    eng_rdy_val = 0; req_tx_valid = 2'b11; eng_tx_ready = 1; req_rx_ready = 2'b11; eng_rx_valid = 1;
    tick();
    #2;
    check("pre_rst_valid", 32'(eng_cmd_valid), 32'd1);
    rst = 1;
    #1;
    check("arst_eng_valid", 32'(eng_cmd_valid), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_owner", 32'(owner), 32'd0);
    check("arst_tx", 32'({eng_tx_valid, req_tx_ready}), 32'd0);
    check("arst_rx", 32'({eng_rx_ready, req_rx_valid}), 32'd0);
    @(posedge clk);
    #1;
    rst = 0; eng_rdy_val = 1; req_tx_valid = '0; eng_tx_ready = 0; req_rx_ready = '0; eng_rx_valid = 0;
    q0.delete(); q1.delete(); model_reset();
    log_q.delete(); exp_log.delete();
    w = word(OP_CFG, 0); push(0, w); exp_log.push_back(w);
    w = word(OP_CFG, 1); push(1, w); exp_log.push_back(w);
    run_idle(10, n);
    check_log("post_rst_ptr");

    // Soft reset during a lock.
    push(1, word(OP_START, 1));
    tick();
    push(1, word(OP_WR, 1));
    sw_rst = 1;
    tick();
    sw_rst = 0;
    check("srst_locked", 32'(locked), 32'd0);
    check("srst_owner", 32'(owner), 32'd0);
    check("srst_not_taken", 32'(q1.size()), 32'd1);
    q1.delete();

    // Randomized traffic against the model.
    rnd_aux = 1; gen = 0; cyc = 0;
    while ((gen < 60 || q0.size() != 0 || q1.size() != 0 || m_state != 0) && cyc < 8000) begin
      if (gen < 60 && $urandom_range(0, 3) == 0) begin
        push_rand_txn($urandom_range(0, NR - 1));
        gen++;
      end
      tick();
      cyc++;
    end
    check("random_drained", 32'(cyc < 8000), 32'd1);
    rnd_aux = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
